pwm_compare_nch: RTL and testbench

PWM_COMPARE_NCH -- requirements
Module: pwm_compare_nch

---
 rtl/pwm_compare_nch.sv | 157 +++++++++++++++
 tb/tb_pwm_compare_nch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_compare_nch.sv
// Multi-channel compare PWM: shadowed compare registers, registered compare, complementary gate outputs.
// Define PWM_DEADTIME_EN to build the per-channel OFF/HIGH/LOW/DEAD dead-time FSM.
module pwm_compare_nch #(
   parameter int WIDTH    = 16,
   parameter int NCH      = 3,
   parameter int DT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     carrier,
   input  logic                 load_strobe,
   input  logic [NCH*WIDTH-1:0] compare_in,
   input  logic [NCH-1:0]       compare_wr,
   input  logic [NCH-1:0]       pwm_onoff,
   input  logic [DT_WIDTH-1:0]  deadtime,
   output logic [NCH-1:0]       pwm_h,
   output logic [NCH-1:0]       pwm_l,
   output logic [NCH-1:0]       shadow_pending
);

   logic [NCH-1:0][WIDTH-1:0] shadow_q, shadow_d;
   logic [NCH-1:0][WIDTH-1:0] active_q, active_d;
   logic [NCH-1:0]            pend_q, pend_d;
   logic [NCH-1:0]            raw_q, raw_d;
   logic [NCH-1:0]            en_q, en_d;
   logic [NCH-1:0]            pwm_h_q, pwm_h_d;
   logic [NCH-1:0]            pwm_l_q, pwm_l_d;

   // A write coinciding with the strobe goes straight to active and leaves nothing pending.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      pend_d   = pend_q;
      raw_d    = '0;
      for (int i = 0; i < NCH; i++) begin
         if (compare_wr[i]) begin
            shadow_d[i] = compare_in[i*WIDTH +: WIDTH];
            pend_d[i]   = 1'b1;
         end
         if (load_strobe) begin
            active_d[i] = compare_wr[i] ? compare_in[i*WIDTH +: WIDTH] : shadow_q[i];
            pend_d[i]   = 1'b0;
         end
         raw_d[i] = (carrier < active_q[i]) && pwm_onoff[i];
      end
   end

   assign en_d = pwm_onoff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q <= '0;
         active_q <= '0;
         pend_q   <= '0;
         raw_q    <= '0;
         en_q     <= '0;
         pwm_h_q  <= '0;
         pwm_l_q  <= '0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         pend_q   <= pend_d;
         raw_q    <= raw_d;
         en_q     <= en_d;
         pwm_h_q  <= pwm_h_d;
         pwm_l_q  <= pwm_l_d;
      end
   end

`ifdef PWM_DEADTIME_EN
   typedef enum logic [1:0] {ST_OFF, ST_HIGH, ST_LOW, ST_DEAD} state_e;

   localparam logic [DT_WIDTH-1:0] DT_ONE = {{(DT_WIDTH-1){1'b0}}, 1'b1};

   state_e              state_q [NCH];
   state_e              state_d [NCH];
   logic [DT_WIDTH-1:0] cnt_q   [NCH];
   logic [DT_WIDTH-1:0] cnt_d   [NCH];
   logic [DT_WIDTH-1:0] dt_q    [NCH];
   logic [DT_WIDTH-1:0] dt_d    [NCH];
   logic [NCH-1:0]      rawd_q, rawd_d;

   // en_q gates leaving OFF so the first decision uses a raw sample taken while enabled.
   always_comb begin
      rawd_d  = raw_q;
      pwm_h_d = '0;
      pwm_l_d = '0;
      for (int i = 0; i < NCH; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         dt_d[i]    = dt_q[i];
         if (!pwm_onoff[i]) begin
            state_d[i] = ST_OFF;
         end else begin
            case (state_q[i])
               ST_OFF, ST_HIGH, ST_LOW: begin
                  if ((state_q[i] == ST_OFF  && en_q[i]) ||
                      (state_q[i] == ST_HIGH && !raw_q[i]) ||
                      (state_q[i] == ST_LOW  && raw_q[i])) begin
                     if (deadtime == '0) begin
                        state_d[i] = raw_q[i] ? ST_HIGH : ST_LOW;
                     end else begin
                        state_d[i] = ST_DEAD;
                        cnt_d[i]   = deadtime;
                        dt_d[i]    = deadtime;
                     end
                  end
               end
               default: begin
                  // Any raw edge while dead restarts the gap from that edge.
                  if (raw_q[i] != rawd_q[i]) begin
                     cnt_d[i] = dt_q[i];
                  end else if (cnt_q[i] <= DT_ONE) begin
                     state_d[i] = raw_q[i] ? ST_HIGH : ST_LOW;
                  end else begin
                     cnt_d[i] = cnt_q[i] - DT_ONE;
                  end
               end
            endcase
         end
         pwm_h_d[i] = (state_d[i] == ST_HIGH);
         pwm_l_d[i] = (state_d[i] == ST_LOW);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rawd_q <= '0;
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= ST_OFF;
            cnt_q[i]   <= '0;
            dt_q[i]    <= '0;
         end
      end else begin
         rawd_q <= rawd_d;
         for (int i = 0; i < NCH; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
            dt_q[i]    <= dt_d[i];
         end
      end
   end
`else
   logic unused_deadtime;
   assign unused_deadtime = ^deadtime;

   always_comb begin
      pwm_h_d = raw_q & pwm_onoff;
      pwm_l_d = ~raw_q & en_q & pwm_onoff;
   end
`endif

   assign pwm_h          = pwm_h_q;
   assign pwm_l          = pwm_l_q;
   assign shadow_pending = pend_q;

endmodule

// File: tb/tb_pwm_compare_nch.sv
// Directed bench for pwm_compare_nch: vector table for compare/shadow behaviour, sequences for dead-time corners.
module tb_pwm_compare_nch;
   localparam int WIDTH    = 16;
   localparam int NCH      = 3;
   localparam int DT_WIDTH = 8;
`ifdef PWM_DEADTIME_EN
   localparam bit DT_ON = 1'b1;
`else
   localparam bit DT_ON = 1'b0;
`endif

   logic                 clk = 1'b0;
   logic                 rst;
   logic [WIDTH-1:0]     carrier;
   logic                 load_strobe;
   logic [NCH*WIDTH-1:0] compare_in;
   logic [NCH-1:0]       compare_wr;
   logic [NCH-1:0]       pwm_onoff;
   logic [DT_WIDTH-1:0]  deadtime;
   logic [NCH-1:0]       pwm_h;
   logic [NCH-1:0]       pwm_l;
   logic [NCH-1:0]       shadow_pending;

   always #5 clk = ~clk;

   pwm_compare_nch #(.WIDTH(WIDTH), .NCH(NCH), .DT_WIDTH(DT_WIDTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .carrier        (carrier),
      .load_strobe    (load_strobe),
      .compare_in     (compare_in),
      .compare_wr     (compare_wr),
      .pwm_onoff      (pwm_onoff),
      .deadtime       (deadtime),
      .pwm_h          (pwm_h),
      .pwm_l          (pwm_l),
      .shadow_pending (shadow_pending)
   );

   typedef struct {
      logic [2:0]  wr;
      logic        ld;
      logic [47:0] cmp;
      logic [2:0]  on;
      logic [15:0] car;
      logic [2:0]  pend;
      logic [2:0]  h;
      logic [2:0]  l;
      logic [15:0] act0;
      logic [15:0] act1;
   } vec_t;

   vec_t vt [13];
   logic h_hist [2600];
   logic l_hist [2600];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Dead-time actually inserted by the build under test.
   function automatic int deff(input int d);
      return DT_ON ? d : 0;
   endfunction

   initial begin
      int d, cnt, ovl;
      logic p500;

      //           wr      ld    cmp {ch2,ch1,ch0}           on      car          pend    h       l       act0      act1
      vt[0]  = '{3'b001, 1'b0, {16'd0, 16'd0, 16'd1000},   3'b111, 16'd500,   3'b001, 3'b000, 3'b111, 16'd0,    16'd0};
      vt[1]  = '{3'b000, 1'b0, {16'd0, 16'd0, 16'd0},      3'b111, 16'd500,   3'b001, 3'b000, 3'b111, 16'd0,    16'd0};
      vt[2]  = '{3'b000, 1'b1, {16'd0, 16'd0, 16'd0},      3'b111, 16'd500,   3'b000, 3'b001, 3'b110, 16'd1000, 16'd0};
      vt[3]  = '{3'b000, 1'b0, {16'd0, 16'd0, 16'd0},      3'b111, 16'd999,   3'b000, 3'b001, 3'b110, 16'd1000, 16'd0};
      vt[4]  = '{3'b000, 1'b0, {16'd0, 16'd0, 16'd0},      3'b111, 16'd1000,  3'b000, 3'b000, 3'b111, 16'd1000, 16'd0};
      vt[5]  = '{3'b010, 1'b1, {16'd0, 16'd500, 16'd0},    3'b111, 16'd499,   3'b000, 3'b011, 3'b100, 16'd1000, 16'd500};
      vt[6]  = '{3'b000, 1'b0, {16'd0, 16'd0, 16'd0},      3'b111, 16'd500,   3'b000, 3'b001, 3'b110, 16'd1000, 16'd500};
      vt[7]  = '{3'b110, 1'b0, {16'd65535, 16'd0, 16'd0},  3'b111, 16'd0,     3'b110, 3'b011, 3'b100, 16'd1000, 16'd500};
      vt[8]  = '{3'b000, 1'b1, {16'd0, 16'd0, 16'd0},      3'b111, 16'd0,     3'b000, 3'b101, 3'b010, 16'd1000, 16'd0};
      vt[9]  = '{3'b000, 1'b0, {16'd0, 16'd0, 16'd0},      3'b111, 16'd65535, 3'b000, 3'b000, 3'b111, 16'd1000, 16'd0};
      vt[10] = '{3'b000, 1'b0, {16'd0, 16'd0, 16'd0},      3'b111, 16'd65534, 3'b000, 3'b100, 3'b011, 16'd1000, 16'd0};
      vt[11] = '{3'b001, 1'b0, {16'd0, 16'd0, 16'd2000},   3'b111, 16'd1500,  3'b001, 3'b100, 3'b011, 16'd1000, 16'd0};
      vt[12] = '{3'b000, 1'b0, {16'd0, 16'd0, 16'd0},      3'b011, 16'd1500,  3'b001, 3'b000, 3'b011, 16'd1000, 16'd0};

      rst = 1'b1; carrier = '0; load_strobe = 1'b0; compare_in = '0;
      compare_wr = '0; pwm_onoff = '0; deadtime = '0;
      @(negedge clk);
      chk("reset_pwm_h", pwm_h, 0);
      chk("reset_pwm_l", pwm_l, 0);
      chk("reset_pending", shadow_pending, 0);
      rst = 1'b0;
      pwm_onoff = 3'b111;
      repeat (4) step();

      // Vector table: inputs held, write/strobe for one cycle, outputs checked after the 2-clk pipe.
      for (int i = 0; i < 13; i++) begin
         compare_in  = vt[i].cmp;
         compare_wr  = vt[i].wr;
         load_strobe = vt[i].ld;
         pwm_onoff   = vt[i].on;
         carrier     = vt[i].car;
         step();
         compare_wr  = '0;
         load_strobe = 1'b0;
         step();
         step();
         chk($sformatf("vec%0d_pending", i), shadow_pending, vt[i].pend);
         chk($sformatf("vec%0d_pwm_h", i), pwm_h, vt[i].h);
         chk($sformatf("vec%0d_pwm_l", i), pwm_l, vt[i].l);
         chk($sformatf("vec%0d_active0", i), dut.active_q[0], vt[i].act0);
         chk($sformatf("vec%0d_active1", i), dut.active_q[1], vt[i].act1);
      end

      // Carrier ramp 0..1999, compare 1000, dead-time 10 (changed mid-count to prove it is latched).
      pwm_onoff = 3'b111;
      deadtime = 8'd10;
      compare_in = {32'd0, 16'd1000};
      compare_wr = 3'b001;
      load_strobe = 1'b1;
      carrier = 16'd1500;
      step();
      compare_wr = '0;
      load_strobe = 1'b0;
      step();
      step();
      for (int j = 0; j < 2500; j++) begin
         h_hist[j] = pwm_h[0];
         l_hist[j] = pwm_l[0];
         carrier = 16'((1500 + j) % 2000);
         if (j == 504) deadtime = 8'd50;
         if (j == 508) deadtime = 8'd10;
         step();
      end
      d = deff(10);
      chk("ramp_l_before_wrap", l_hist[501], 1);
      chk("ramp_l_fall", l_hist[502], 0);
      chk("ramp_h_before_rise", h_hist[501 + d], 0);
      chk("ramp_h_rise", h_hist[502 + d], 1);
      chk("ramp_h_before_fall", h_hist[1501], 1);
      chk("ramp_h_fall", h_hist[1502], 0);
      chk("ramp_l_before_rise", l_hist[1501 + d], 0);
      chk("ramp_l_rise", l_hist[1502 + d], 1);
      ovl = 0;
      for (int j = 0; j < 2500; j++) if (h_hist[j] && l_hist[j]) ovl++;
      chk("ramp_overlap", ovl, 0);
      cnt = 0;
      for (int j = 500; j < 540; j++) if (!h_hist[j] && !l_hist[j]) cnt++;
      chk("ramp_gap_rise_h", cnt, d);
      cnt = 0;
      for (int j = 1500; j < 1540; j++) if (!h_hist[j] && !l_hist[j]) cnt++;
      chk("ramp_gap_rise_l", cnt, d);

      // Compare reloaded 1000 -> 1005 just after the crossing: raw glitches and the gap restarts.
      deadtime = 8'd20;
      compare_in = {32'd0, 16'd1005};
      p500 = 1'b0;
      for (int k = 0; k < 1100; k++) begin
         h_hist[k] = pwm_h[0];
         l_hist[k] = pwm_l[0];
         if (k == 500) p500 = shadow_pending[0];
         carrier = 16'(k);
         compare_wr = (k == 100) ? 3'b001 : 3'b000;
         load_strobe = (k == 1001);
         step();
      end
      compare_wr = '0;
      load_strobe = 1'b0;
      d = deff(20);
      chk("glitch_h_before_rise", h_hist[1 + d], 0);
      chk("glitch_h_rise", h_hist[2 + d], 1);
      chk("glitch_pending_held", p500, 1);
      chk("glitch_h_before_fall", h_hist[1001], 1);
      cnt = 0;
      for (int k = 1002; k < 1027; k++) if (!h_hist[k] && !l_hist[k]) cnt++;
      chk("glitch_both_low", cnt, DT_ON ? 25 : 0);
      chk("glitch_l_before_rise", l_hist[1026], DT_ON ? 0 : 1);
      chk("glitch_l_rise", l_hist[1027], 1);
      chk("glitch_h_after", h_hist[1027], 0);
      chk("glitch_active0", dut.active_q[0], 1005);
      chk("glitch_pending_clear", shadow_pending[0], 0);

      // Enable dropped while HIGH, then re-enabled.
      deadtime = 8'd5;
      carrier = 16'd0;
      repeat (30) step();
      chk("onoff_hold_high", pwm_h[0], 1);
      pwm_onoff[0] = 1'b0;
      step();
      chk("onoff_drop_h", pwm_h[0], 0);
      chk("onoff_drop_l", pwm_l[0], 0);
      repeat (3) step();
      pwm_onoff[0] = 1'b1;
      d = deff(5);
      cnt = 0;
      for (int s = 1; s <= d + 2; s++) begin
         step();
         if (s <= d + 1 && !pwm_h[0] && !pwm_l[0]) cnt++;
      end
      chk("reenable_gap", cnt, d + 1);
      chk("reenable_h", pwm_h[0], 1);

      // Asynchronous reset between edges while HIGH.
      repeat (10) step();
      chk("pre_reset_high", pwm_h[0], 1);
      #2 rst = 1'b1;
      #1;
      chk("async_reset_h", pwm_h, 0);
      chk("async_reset_l", pwm_l, 0);
      chk("async_reset_pending", shadow_pending, 0);
      @(negedge clk);
      rst = 1'b0;
      chk("post_reset_active0", dut.active_q[0], 0);
      cnt = 0;
      for (int s = 1; s <= d + 2; s++) begin
         step();
         if (s <= d + 1 && !pwm_h[0] && !pwm_l[0]) cnt++;
      end
      chk("post_reset_gap", cnt, d + 1);
      chk("post_reset_l", pwm_l[0], 1);
      chk("post_reset_h", pwm_h[0], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
